// File: rtl/dla_platform_hw_timer_multi.sv
// Multi-channel cycle timer with start/stop/resume control, atomic snapshot and shadow read port.
// Latency: control pulses act at the next clk edge; read response 1 cycle after i_rd_valid.
// Backpressure: none; control pulses and reads are accepted every cycle.
// Ports: clk, i_sclr (sync active-high reset); i_start/i_stop/i_resume per-channel pulses;
//   i_snapshot captures all channels into shadow; i_rd_valid/i_rd_channel read request;
//   o_rd_valid/o_rd_data/o_rd_overflow/o_rd_running/o_rd_error read response; o_running live flags.
module dla_platform_hw_timer_multi #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter bit SATURATE      = 1'b1,
  parameter int CH_IDX_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     i_sclr,
  input  logic [NUM_CHANNELS-1:0]  i_start,
  input  logic [NUM_CHANNELS-1:0]  i_stop,
  input  logic [NUM_CHANNELS-1:0]  i_resume,
  input  logic                     i_snapshot,
  input  logic                     i_rd_valid,
  input  logic [CH_IDX_WIDTH-1:0]  i_rd_channel,
  output logic                     o_rd_valid,
  output logic [COUNTER_WIDTH-1:0] o_rd_data,
  output logic                     o_rd_overflow,
  output logic                     o_rd_running,
  output logic                     o_rd_error,
  output logic [NUM_CHANNELS-1:0]  o_running
);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;
  localparam cnt_t CNT_MAX    = '1;
  localparam cnt_t CNT_MAX_M1 = CNT_MAX - cnt_t'(1);

  // Live per-channel state
  cnt_t                    count_q [NUM_CHANNELS];
  cnt_t                    count_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;
  logic [NUM_CHANNELS-1:0] run_q, run_d;
  // at_max_q[i] is 1 exactly when count_q[i] is all-ones. It is computed one
  // cycle ahead from count_q == MAX-1, so the wide all-ones compare sits in
  // parallel with the incrementer instead of after it.
  logic [NUM_CHANNELS-1:0] at_max_q, at_max_d;

  // Shadow copies captured by i_snapshot
  cnt_t                    shadow_count_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] shadow_ovf_q;
  logic [NUM_CHANNELS-1:0] shadow_run_q;

  // Read response registers
  logic rd_valid_q;
  cnt_t rd_data_q;
  logic rd_ovf_q, rd_run_q, rd_err_q;

  // Shadow read mux
  cnt_t sel_data;
  logic sel_ovf, sel_run, sel_hit;

  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    run_d    = run_q;
    at_max_d = at_max_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (i_start[i]) begin
        // Start clears the channel; a simultaneous stop leaves it cleared but idle.
        count_d[i]  = '0;
        ovf_d[i]    = 1'b0;
        at_max_d[i] = 1'b0;
        run_d[i]    = ~i_stop[i];
      end else if (i_stop[i]) begin
        run_d[i] = 1'b0;
      end else if (i_resume[i]) begin
        run_d[i] = 1'b1;
      end else if (run_q[i]) begin
        if (at_max_q[i]) begin
          ovf_d[i] = 1'b1;
          if (!SATURATE) begin
            count_d[i]  = '0;
            at_max_d[i] = 1'b0;
          end
        end else begin
          count_d[i]  = count_q[i] + cnt_t'(1);
          at_max_d[i] = (count_q[i] == CNT_MAX_M1);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    sel_run  = 1'b0;
    sel_hit  = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (i_rd_channel == CH_IDX_WIDTH'(i)) begin
        sel_data = shadow_count_q[i];
        sel_ovf  = shadow_ovf_q[i];
        sel_run  = shadow_run_q[i];
        sel_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count_q[i]        <= '0;
        shadow_count_q[i] <= '0;
      end
      ovf_q        <= '0;
      run_q        <= '0;
      at_max_q     <= '0;
      shadow_ovf_q <= '0;
      shadow_run_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_ovf_q     <= 1'b0;
      rd_run_q     <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      run_q      <= run_d;
      at_max_q   <= at_max_d;
      rd_valid_q <= i_rd_valid;
      // Snapshot takes the pre-update live values, so a same-cycle start is
      // captured as the value before clearing.
      if (i_snapshot) begin
        shadow_count_q <= count_q;
        shadow_ovf_q   <= ovf_q;
        shadow_run_q   <= run_q;
      end
      // Reads see the shadow before any same-cycle snapshot lands.
      if (i_rd_valid) begin
        rd_data_q <= sel_data;
        rd_ovf_q  <= sel_ovf;
        rd_run_q  <= sel_run;
        rd_err_q  <= ~sel_hit;
      end
    end
  end

  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_overflow = rd_ovf_q;
  assign o_rd_running  = rd_run_q;
  assign o_rd_error    = rd_err_q;
  assign o_running     = run_q;

endmodule

// File: tb/tb_dla_platform_hw_timer_multi.sv
// Testbench for dla_platform_hw_timer_multi: three instances sharing stimulus
// (4ch/32b/saturate, 3ch/8b/wrap, 3ch/8b/saturate), a directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_dla_platform_hw_timer_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sclr   = 1'b1;
  logic [3:0] start  = '0;
  logic [3:0] stop   = '0;
  logic [3:0] resume = '0;
  logic       snap   = 1'b0;
  logic       rd     = 1'b0;
  logic [1:0] rd_ch  = '0;

  logic        a_vld, a_ovf, a_run, a_err;
  logic [31:0] a_data;
  logic [3:0]  a_running;
  logic        b_vld, b_ovf, b_run, b_err;
  logic [7:0]  b_data;
  logic [2:0]  b_running;
  logic        c_vld, c_ovf, c_run, c_err;
  logic [7:0]  c_data;
  logic [2:0]  c_running;

  int ncomp = 0;
  int nerr  = 0;
  bit chk_on = 1'b0;

  dla_platform_hw_timer_multi #(.NUM_CHANNELS(4), .COUNTER_WIDTH(32), .SATURATE(1'b1), .CH_IDX_WIDTH(2)) dut_a (
    .clk(clk), .i_sclr(sclr), .i_start(start), .i_stop(stop), .i_resume(resume),
    .i_snapshot(snap), .i_rd_valid(rd), .i_rd_channel(rd_ch),
    .o_rd_valid(a_vld), .o_rd_data(a_data), .o_rd_overflow(a_ovf), .o_rd_running(a_run),
    .o_rd_error(a_err), .o_running(a_running));

  dla_platform_hw_timer_multi #(.NUM_CHANNELS(3), .COUNTER_WIDTH(8), .SATURATE(1'b0), .CH_IDX_WIDTH(2)) dut_b (
    .clk(clk), .i_sclr(sclr), .i_start(start[2:0]), .i_stop(stop[2:0]), .i_resume(resume[2:0]),
    .i_snapshot(snap), .i_rd_valid(rd), .i_rd_channel(rd_ch),
    .o_rd_valid(b_vld), .o_rd_data(b_data), .o_rd_overflow(b_ovf), .o_rd_running(b_run),
    .o_rd_error(b_err), .o_running(b_running));

  dla_platform_hw_timer_multi #(.NUM_CHANNELS(3), .COUNTER_WIDTH(8), .SATURATE(1'b1), .CH_IDX_WIDTH(2)) dut_c (
    .clk(clk), .i_sclr(sclr), .i_start(start[2:0]), .i_stop(stop[2:0]), .i_resume(resume[2:0]),
    .i_snapshot(snap), .i_rd_valid(rd), .i_rd_channel(rd_ch),
    .o_rd_valid(c_vld), .o_rd_data(c_data), .o_rd_overflow(c_ovf), .o_rd_running(c_run),
    .o_rd_error(c_err), .o_running(c_running));

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
    logic        ovf;
    logic        run;
    logic        err;
    logic [3:0]  running;
  } obs_t;

  // ---------------- reference model ----------------
  longint unsigned m_cnt    [3][4];
  longint unsigned m_sh_cnt [3][4];
  bit              m_ovf    [3][4];
  bit              m_run    [3][4];
  bit              m_sh_ovf [3][4];
  bit              m_sh_run [3][4];
  bit              m_rd_vld [3];
  bit              m_rd_ovf [3];
  bit              m_rd_run [3];
  bit              m_rd_err [3];
  longint unsigned m_rd_data[3];

  function automatic int nc_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction
  function automatic longint unsigned max_of(int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'd255;
  endfunction
  function automatic bit sat_of(int d);
    return d != 1;
  endfunction

  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      if (sclr) begin
        m_rd_vld[d] = 0; m_rd_data[d] = 0; m_rd_ovf[d] = 0; m_rd_run[d] = 0; m_rd_err[d] = 0;
        for (int ch = 0; ch < 4; ch++) begin
          m_cnt[d][ch] = 0; m_ovf[d][ch] = 0; m_run[d][ch] = 0;
          m_sh_cnt[d][ch] = 0; m_sh_ovf[d][ch] = 0; m_sh_run[d][ch] = 0;
        end
      end else begin
        m_rd_vld[d] = rd;
        if (rd) begin
          if (int'(rd_ch) >= nc_of(d)) begin
            m_rd_data[d] = 0; m_rd_ovf[d] = 0; m_rd_run[d] = 0; m_rd_err[d] = 1;
          end else begin
            m_rd_data[d] = m_sh_cnt[d][rd_ch];
            m_rd_ovf[d]  = m_sh_ovf[d][rd_ch];
            m_rd_run[d]  = m_sh_run[d][rd_ch];
            m_rd_err[d]  = 0;
          end
        end
        for (int ch = 0; ch < nc_of(d); ch++) begin
          if (snap) begin
            m_sh_cnt[d][ch] = m_cnt[d][ch];
            m_sh_ovf[d][ch] = m_ovf[d][ch];
            m_sh_run[d][ch] = m_run[d][ch];
          end
          if (start[ch]) begin
            m_cnt[d][ch] = 0; m_ovf[d][ch] = 0; m_run[d][ch] = !stop[ch];
          end else if (stop[ch]) begin
            m_run[d][ch] = 0;
          end else if (resume[ch]) begin
            m_run[d][ch] = 1;
          end else if (m_run[d][ch]) begin
            if (m_cnt[d][ch] == max_of(d)) begin
              m_ovf[d][ch] = 1;
              m_cnt[d][ch] = sat_of(d) ? max_of(d) : 0;
            end else begin
              m_cnt[d][ch] = m_cnt[d][ch] + 1;
            end
          end
        end
      end
    end
  endtask

  function automatic obs_t exp_obs(int d);
    obs_t o;
    o = '0;
    o.vld  = m_rd_vld[d];
    o.data = 32'(m_rd_data[d]);
    o.ovf  = m_rd_ovf[d];
    o.run  = m_rd_run[d];
    o.err  = m_rd_err[d];
    for (int ch = 0; ch < nc_of(d); ch++) o.running[ch] = m_run[d][ch];
    return o;
  endfunction

  function automatic obs_t act_obs(int d);
    obs_t o;
    case (d)
      0:       o = {a_vld, a_data, a_ovf, a_run, a_err, a_running};
      1:       o = {b_vld, 24'd0, b_data, b_ovf, b_run, b_err, 1'b0, b_running};
      default: o = {c_vld, 24'd0, c_data, c_ovf, c_run, c_err, 1'b0, c_running};
    endcase
    return o;
  endfunction

  initial forever begin
    @(posedge clk);
    model_update();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        obs_t a, e;
        a = act_obs(d);
        e = exp_obs(d);
        ncomp++;
        if (a !== e) begin
          nerr++;
          $display("FAIL model_dut%0d t=%0t: got vld=%0b data=%0d ovf=%0b run=%0b err=%0b running=%b, want vld=%0b data=%0d ovf=%0b run=%0b err=%0b running=%b",
                   d, $time, a.vld, a.data, a.ovf, a.run, a.err, a.running,
                   e.vld, e.data, e.ovf, e.run, e.err, e.running);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step(logic [3:0] st, logic [3:0] sp, logic [3:0] rs, logic sn, logic r, logic [1:0] ch);
    @(negedge clk);
    sclr = 1'b0; start = st; stop = sp; resume = rs; snap = sn; rd = r; rd_ch = ch;
  endtask

  task automatic idle(int n);
    repeat (n) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic chk_val(string nm, longint unsigned act, longint unsigned exp);
    ncomp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(string nm, int d);
    obs_t o;
    o = act_obs(d);
    ncomp++;
    if (o !== '0) begin
      nerr++;
      $display("FAIL %s dut%0d: got vld=%0b data=%0d ovf=%0b run=%0b err=%0b running=%b, expected all 0",
               nm, d, o.vld, o.data, o.ovf, o.run, o.err, o.running);
    end
  endtask

  task automatic chk_rd(string nm, int d, longint unsigned data, bit ovf, bit run, bit err);
    obs_t o;
    o = act_obs(d);
    ncomp++;
    if (o.vld !== 1'b1 || o.data !== 32'(data) || o.ovf !== ovf || o.run !== run || o.err !== err) begin
      nerr++;
      $display("FAIL %s dut%0d: got vld=%0b data=%0d ovf=%0b run=%0b err=%0b, expected vld=1 data=%0d ovf=%0b run=%0b err=%0b",
               nm, d, o.vld, o.data, o.ovf, o.run, o.err, data, ovf, run, err);
    end
  endtask

  typedef struct {
    logic [3:0] start, stop, resume;
    logic       snap;
    int         idle;
    logic       rd;
    logic [1:0] ch;
    int         dut;
    int         edata;
    logic       eovf, erun, eerr;
  } vec_t;

  function automatic vec_t v(logic [3:0] st, logic [3:0] sp, logic [3:0] rs, logic sn, int idl,
                             logic r, logic [1:0] ch, int d, int edata, logic eo, logic er, logic ee);
    vec_t x;
    x.start = st; x.stop = sp; x.resume = rs; x.snap = sn; x.idle = idl;
    x.rd = r; x.ch = ch; x.dut = d; x.edata = edata; x.eovf = eo; x.erun = er; x.eerr = ee;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    // Directed vectors; dut 0 = 4ch/32b/sat, 1 = 3ch/8b/wrap, 2 = 3ch/8b/sat.
    // Basic count on ch0: start, 100 idle cycles, stop -> 100.
    tbl.push_back(v(4'b0001, 4'b0000, 4'b0000, 0, 100, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0001, 4'b0000, 0,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 1,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 0, 0, 100, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 0, 1, 100, 0, 0, 0));
    // Stop/resume on ch3: 10, hold 40 idle cycles, resume for 5 -> 15.
    tbl.push_back(v(4'b1000, 4'b0000, 4'b0000, 0,  10, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b1000, 4'b0000, 0,  40, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b1000, 0,   5, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b1000, 4'b0000, 0,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 1,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 3, 0,  15, 0, 0, 0));
    // Overflow on ch0: 300 increments -> wrap 44, saturate 255, 32-bit 300.
    tbl.push_back(v(4'b0001, 4'b0000, 4'b0000, 0, 300, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0001, 4'b0000, 0,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 1,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 0, 1,  44, 1, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 0, 2, 255, 1, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 0, 0, 300, 0, 0, 0));
    // A new start clears overflow; snapshot right after sees count 0, running.
    tbl.push_back(v(4'b0001, 4'b0000, 4'b0000, 0,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 1,   0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 0, 1,   0, 0, 1, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 0, 2,   0, 0, 1, 0));
    tbl.push_back(v(4'b0000, 4'b0001, 4'b0000, 0,   0, 0, 0, 0,   0, 0, 0, 0));
    // Out-of-range index on the 3-channel instances; in range on the 4-channel one.
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 3, 1,   0, 0, 0, 1));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 3, 2,   0, 0, 0, 1));
    tbl.push_back(v(4'b0000, 4'b0000, 4'b0000, 0,   0, 1, 3, 0,  15, 0, 0, 0));

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_zero("reset_state", d);
    chk_on = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].start, tbl[k].stop, tbl[k].resume, tbl[k].snap, tbl[k].rd, tbl[k].ch);
      if (tbl[k].rd) begin
        idle(1);
        chk_rd($sformatf("tbl[%0d]", k), tbl[k].dut, longint'(tbl[k].edata),
               tbl[k].eovf, tbl[k].erun, tbl[k].eerr);
      end
      idle(tbl[k].idle);
    end

    // Stop and resume together keep ch3 idle; resume alone restarts it.
    step(4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0, 2'd0);
    idle(1);
    chk_val("stop_resume_same_cycle", a_running[3], 0);
    step(4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 2'd0);
    idle(1);
    chk_val("resume_alone", a_running[3], 1);
    step(4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0);
    idle(1);
    chk_val("stop_again", a_running[3], 0);

    // Independent channels, back-to-back reads.
    step(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    idle(49);
    step(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    idle(200);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2);
    chk_rd("indep_ch1", 0, 250, 0, 1, 0);
    idle(1);
    chk_rd("indep_ch2", 0, 200, 0, 1, 0);
    step(4'b0000, 4'b0110, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Start and stop together on a running ch0.
    step(4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0);
    idle(3);
    chk_val("ch0_resumed", a_running[0], 1);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
    idle(1);
    chk_val("start_stop_running", a_running[0], 0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);
    idle(1);
    chk_rd("start_stop_count", 0, 0, 0, 0, 0);

    // Snapshot with a start on ch1 at count 77 captures 77; read with snapshot returns old shadow.
    step(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    idle(77);
    step(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    idle(1);
    chk_rd("snap_with_start", 0, 77, 0, 1, 0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1);
    idle(1);
    chk_rd("read_with_snap_old", 0, 77, 0, 1, 0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    idle(1);
    chk_rd("read_after_snap_new", 0, 2, 0, 1, 0);

    // Reset mid-count overrides every control input in the same cycle.
    @(negedge clk);
    sclr = 1'b1; start = 4'hF; stop = 4'h0; resume = 4'hF; snap = 1'b1; rd = 1'b1; rd_ch = 2'd1;
    idle(1);
    for (int d = 0; d < 3; d++) chk_zero("reset_midcount", d);
    idle(5);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    idle(1);
    chk_rd("reset_no_resume", 0, 0, 0, 0, 0);
    chk_val("reset_running", a_running, 0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      sclr = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 4; i++) begin
        start[i]  = ($urandom_range(0, 999) < 4);
        stop[i]   = ($urandom_range(0, 999) < 15);
        resume[i] = ($urandom_range(0, 999) < 30);
      end
      snap  = ($urandom_range(0, 9) == 0);
      rd    = 1'($urandom_range(0, 1));
      rd_ch = 2'($urandom_range(0, 3));
    end
    idle(3);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
    $finish;
  end

endmodule

// File: doc/dla_platform_hw_timer_multi.md
# dla_platform_hw_timer_multi

Multi-channel cycle timer used by the host to measure CoreDLA IP clock frequency and per-phase execution time. It provides NUM_CHANNELS independent counters with start/stop/resume control, sticky overflow, and a selectable saturate or wrap overflow mode. An atomic snapshot captures every channel in the same cycle into shadow registers, and a single registered read port returns the captured values. The block sits in the platform CSR domain, on the IP clock, behind the host register decoder.

## Interface
- NUM_CHANNELS, 4: number of independent counters, 1..16.
- COUNTER_WIDTH, 32: counter width in bits, 8..64.
- SATURATE, 1: 1 = counter holds at all-ones on overflow; 0 = counter wraps to 0.
- CH_IDX_WIDTH, $clog2(NUM_CHANNELS) (minimum 1): width of the read channel index.

- clk  input  1  sole clock.
- i_sclr  input  1  synchronous active-high reset.
- i_start  input  NUM_CHANNELS  per-channel pulse: clear counter and overflow flag, begin running.
- i_stop  input  NUM_CHANNELS  per-channel pulse: halt counting and hold the value.
- i_resume  input  NUM_CHANNELS  per-channel pulse: continue counting from the held value without clearing.
- i_snapshot  input  1  pulse: capture all counters and status into shadow registers.
- i_rd_valid  input  1  read request.
- i_rd_channel  input  CH_IDX_WIDTH  channel index to read from the shadow registers.
- o_rd_valid  output  1  read response valid, one cycle after the request.
- o_rd_data  output  COUNTER_WIDTH  shadow counter value of the requested channel.
- o_rd_overflow  output  1  shadow overflow flag of the requested channel.
- o_rd_running  output  1  shadow running flag of the requested channel.
- o_rd_error  output  1  requested channel index is ≥ NUM_CHANNELS.
- o_running  output  NUM_CHANNELS  live running flag per channel.

## Operation
- **Per-channel state:** `running` (1 bit), `count` (COUNTER_WIDTH), `ovf` (1 bit, sticky).
- **Control priority per channel, within one cycle (highest first):**
  - start with stop: count ← 0, ovf ← 0, running ← 0.
  - start alone: count ← 0, ovf ← 0, running ← 1. A start while already running restarts from 0.
  - stop with or without resume: running ← 0. Stop wins.
  - resume alone: running ← 1. count and ovf are unchanged.
  - none: if running, count advances as described below.
- **Counting:** the count advances only when running was 1 at the start of the cycle and no start occurs in that cycle.
  - Below all-ones: count ← count + 1.
  - At all-ones with SATURATE=1: count holds at all-ones and ovf ← 1. The channel keeps running.
  - At all-ones with SATURATE=0: count ← 0 and ovf ← 1.
- **Stopped channels:** hold count and ovf indefinitely.
- **Snapshot:**
  - On i_snapshot, shadow_count[i] ← count[i], shadow_ovf[i] ← ovf[i], and shadow_run[i] ← running[i] for every i. These are the register values before this cycle's update.
  - A snapshot in the same cycle as a start on channel i captures the pre-clear value.
- **Read:**
  - On i_rd_valid, the response registers load from the shadow entry at i_rd_channel, and o_rd_valid is 1 on the next cycle.
  - A read in the same cycle as i_snapshot returns the old shadow contents.
  - A channel index ≥ NUM_CHANNELS returns o_rd_data = 0, o_rd_overflow = 0, o_rd_running = 0, and o_rd_error = 1.
  - o_rd_error is 0 on every valid read.
  - When no read is requested, o_rd_valid is 0. The data outputs then hold their last values.
- **Back-to-back reads** are accepted every cycle. There is no backpressure.

## Timing
- **Reset:**
  - i_sclr sampled high clears all count, ovf, running, shadow, and response registers.
  - All outputs read 0 on the cycle after reset: o_rd_valid, o_rd_data, o_rd_overflow, o_rd_running, o_rd_error, o_running.
  - i_sclr overrides every control input in the same cycle.
  - Reset mid-count discards the count. Counting does not resume after reset until a start or resume pulse arrives.
- **Control latency:**
  - Start at edge N: count = 0 after edge N, 1 after edge N+1, k after edge N+k.
  - Stop at edge N: the value after edge N equals the value before it. There is no further increment.
  - o_running reflects start, stop, and resume one cycle after the pulse.
- **Read latency:** exactly 1 cycle from i_rd_valid to o_rd_valid.
- **Snapshot-to-read latency:** a read issued the cycle after i_snapshot returns the new shadow contents.
- **Critical path:** the COUNTER_WIDTH incrementer plus the all-ones compare. At COUNTER_WIDTH=64 the compare is registered as a one-cycle-ahead `next_is_max` flag, with no change in visible behaviour.

## Test plan
- **Basic count:** NUM_CHANNELS=4, start ch0, wait 100 cycles, stop, snapshot, read ch0 → o_rd_data = 100, overflow 0, running 0, error 0.
- **Independent channels:** start ch1, resume is absent, start ch2 50 cycles later, snapshot after 200 more cycles, then read ch1 and ch2 back-to-back → 250 and 200, both running 1, responses on consecutive cycles.
- **Stop/resume:** start ch3, stop at count 10, idle 40 cycles, resume, run 5 cycles, stop, snapshot, read → 15. Then pulse stop and resume in the same cycle → running stays 0.
- **Overflow:** COUNTER_WIDTH=8.
  - With SATURATE=1, run 300 cycles → 255 with overflow 1.
  - With SATURATE=0, run 300 cycles → 44 with overflow 1.
  - A subsequent start clears overflow to 0.
- **Simultaneous events:**
  - Start and stop on ch0 in the same cycle → count 0, running 0.
  - Snapshot together with a start on a channel at count 77 → shadow holds 77.
  - Read together with snapshot → previous shadow value returned.
- **Reset and error:**
  - Assert i_sclr mid-count → all outputs 0 the next cycle, and the counter stays 0 with no start.
  - With NUM_CHANNELS=3 and CH_IDX_WIDTH=2, read index 3 → o_rd_valid 1, o_rd_error 1, o_rd_data 0.
